// File: rtl/spi_slave.sv
// SPI mode-0 byte slave.
// sclk and ss are sampled straight into clk-domain edge detectors.
// Each received byte is echoed back on miso during the following byte.
module spi_slave (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] data,
  output logic       valid,
  output logic       sot,
  output logic       eot
);

  logic       sclk_prev_q, sclk_prev_d;
  logic       ss_prev_q,   ss_prev_d;
  // Stays 0 until ss has been seen high after reset. A select that is
  // already low when reset releases therefore does not look like a fresh
  // falling edge, so that transfer gets no sot.
  logic       seen_high_q, seen_high_d;
  logic [2:0] bit_cnt_q,   bit_cnt_d;
  logic [7:0] rx_sr_q,     rx_sr_d;
  logic [7:0] tx_sr_q,     tx_sr_d;
  logic [7:0] data_q,      data_d;
  logic       valid_q,     valid_d;
  logic       sot_q,       sot_d;
  logic       eot_q,       eot_d;
  logic       first_q,     first_d;

  logic       sclk_rise;
  logic       sclk_fall;
  logic       ss_fall;
  logic       ss_rise;
  logic       byte_done;
  logic [7:0] rx_next;

  // Edge detection and next-state computation for all registers.
  always_comb begin
    sclk_rise = sclk & ~sclk_prev_q;
    sclk_fall = ~sclk & sclk_prev_q;
    ss_fall   = ~ss & ss_prev_q & seen_high_q;
    ss_rise   = ss & ~ss_prev_q;
    rx_next   = {rx_sr_q[6:0], mosi};
    byte_done = sclk_rise & ~ss & (bit_cnt_q == 3'd7);

    sclk_prev_d = sclk;
    ss_prev_d   = ss;
    seen_high_d = seen_high_q | ss;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    sot_d       = 1'b0;
    eot_d       = ss_rise;
    first_d     = first_q;

    // Receive path: idle select holds the counter and shifter at zero,
    // which also throws away a partial byte cut short by ss rising.
    if (ss) begin
      bit_cnt_d = 3'd0;
      rx_sr_d   = 8'h00;
    end else if (sclk_rise) begin
      rx_sr_d   = rx_next;
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    // The 8th rise publishes the byte in the same clk edge.
    if (byte_done) begin
      data_d  = rx_next;
      valid_d = 1'b1;
      sot_d   = first_q;
    end

    if (ss_fall) begin
      first_d = 1'b1;
    end else if (byte_done) begin
      first_d = 1'b0;
    end

    // Transmit path. The fall right after the 8th rise happens with the
    // counter back at 0 and must not shift, otherwise the MSB of the
    // freshly loaded echo byte would be lost before the master samples it.
    if (ss || ss_fall) begin
      tx_sr_d = 8'h00;
    end else if (byte_done) begin
      tx_sr_d = rx_next;
    end else if (sclk_fall && (bit_cnt_q != 3'd0)) begin
      tx_sr_d = {tx_sr_q[6:0], 1'b0};
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      seen_high_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_sr_q     <= 8'h00;
      tx_sr_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      sot_q       <= 1'b0;
      eot_q       <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      seen_high_q <= seen_high_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sot_q       <= sot_d;
      eot_q       <= eot_d;
      first_q     <= first_d;
    end
  end

  assign miso  = ~ss & tx_sr_q[7];
  assign data  = data_q;
  assign valid = valid_q;
  assign sot   = sot_q;
  assign eot   = eot_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed plus randomized bench for spi_slave with a byte-level reference
// model: expected data is the byte sent, the echo is the previous byte of
// the same transfer (0x00 for the first byte), and sot marks the first byte.
module tb_spi_slave;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       ss;
  logic       mosi;
  logic       miso;
  logic [7:0] data;
  logic       valid;
  logic       sot;
  logic       eot;

  int tests = 0;
  int fails = 0;

  logic [7:0] model_data;
  logic [7:0] model_echo;
  bit         model_first;

  spi_slave dut (
    .clk  (clk),
    .rst  (rst),
    .sclk (sclk),
    .ss   (ss),
    .mosi (mosi),
    .miso (miso),
    .data (data),
    .valid(valid),
    .sot  (sot),
    .eot  (eot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_data"},  data, 8'h00);
    chk({tag, "_valid"}, 8'(valid), 8'h00);
    chk({tag, "_sot"},   8'(sot), 8'h00);
    chk({tag, "_eot"},   8'(eot), 8'h00);
    chk({tag, "_miso"},  8'(miso), 8'h00);
  endtask

  task automatic start_xfer();
    ss = 1'b0;
    tick();
    model_first = 1'b1;
    model_echo  = 8'h00;
    chk("start_valid", 8'(valid), 8'h00);
  endtask

  task automatic end_xfer();
    ss   = 1'b1;
    sclk = 1'b0;
    tick();
    chk("eot_pulse", 8'(eot), 8'h01);
    chk("eot_valid", 8'(valid), 8'h00);
    chk("eot_sot",   8'(sot), 8'h00);
    chk("idle_miso", 8'(miso), 8'h00);
    tick();
    chk("eot_clear", 8'(eot), 8'h00);
    chk("data_hold", data, model_data);
  endtask

  // One byte, MSB first; each sclk phase lasts one clk. miso is captured
  // just before each rise, where a mode-0 master samples it.
  task automatic send_byte(input logic [7:0] b, input bit merge_ss);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      sclk = 1'b1;
      if (merge_ss && i == 7) begin
        ss          = 1'b0;
        model_first = 1'b1;
        model_echo  = 8'h00;
      end
      m[i] = miso;
      tick();
      if (i == 0) begin
        chk("byte_valid", 8'(valid), 8'h01);
        chk("byte_data",  data, b);
        chk("byte_sot",   8'(sot), 8'(model_first));
      end else begin
        chk("bit_valid", 8'(valid), 8'h00);
        chk("bit_sot",   8'(sot), 8'h00);
      end
      sclk = 1'b0;
      tick();
      chk("low_valid", 8'(valid), 8'h00);
    end
    chk("miso_echo", m, model_echo);
    model_echo  = b;
    model_first = 1'b0;
    model_data  = b;
  endtask

  task automatic partial(input int n);
    for (int i = 0; i < n; i++) begin
      mosi = 1'($urandom_range(0, 1));
      sclk = 1'b1;
      tick();
      chk("partial_valid", 8'(valid), 8'h00);
      sclk = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst  = 1'b1;
    ss   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    model_data  = 8'h00;
    model_echo  = 8'h00;
    model_first = 1'b0;
    tick();
    chk_outputs_zero("reset");
    rst = 1'b0;
    tick();
    tick();
    chk_outputs_zero("post_reset");

    // All-ones byte then release.
    start_xfer();
    send_byte(8'hFF, 1'b0);
    end_xfer();

    // Four-byte transfer, sot only on the first.
    start_xfer();
    for (int i = 0; i < 4; i++) send_byte(8'(i), 1'b0);
    end_xfer();

    // Partial byte discarded, next full byte is a fresh first byte.
    start_xfer();
    partial(5);
    end_xfer();
    start_xfer();
    send_byte(8'hA5, 1'b0);
    end_xfer();

    // Echo check across a two-byte transfer.
    start_xfer();
    send_byte(8'h3C, 1'b0);
    send_byte(8'h81, 1'b0);
    end_xfer();

    // Reset mid-byte, then a clean transfer.
    start_xfer();
    partial(4);
    rst = 1'b1;
    ss  = 1'b1;
    #1;
    chk_outputs_zero("midbyte_reset");
    tick();
    chk_outputs_zero("midbyte_reset_hold");
    rst = 1'b0;
    model_data = 8'h00;
    tick();
    chk("reset_data", data, 8'h00);
    start_xfer();
    send_byte(8'h5A, 1'b0);
    end_xfer();

    // Reset released with ss already low: bytes arrive but sot stays low.
    ss  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_data  = 8'h00;
    model_echo  = 8'h00;
    model_first = 1'b0;
    tick();
    send_byte(8'hC3, 1'b0);
    send_byte(8'h17, 1'b0);
    end_xfer();

    // ss fall in the same cycle as the first sclk rise.
    send_byte(8'h96, 1'b1);
    send_byte(8'h69, 1'b0);
    end_xfer();

    // Randomized transfers.
    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(1, 4);
      start_xfer();
      for (int k = 0; k < n; k++) send_byte(8'($urandom), 1'b0);
      end_xfer();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
